fpnew_result_buffer: RTL and testbench

FPNEW_RESULT_BUFFER -- requirements
Module: fpnew_result_buffer

---
 rtl/fpnew_pkg.sv | 13 +
 rtl/fpnew_result_buffer.sv | 125 ++++++++++++
 tb/tb_fpnew_result_buffer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fpnew_pkg.sv
// Shared FPnew types used by the result buffer: the IEEE-754 exception flags.
package fpnew_pkg;

    // IEEE-754 exception flags, invalid-operation flag in the MSB.
    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

endpackage

// File: rtl/fpnew_result_buffer.sv
// In-order result FIFO that sits after an FPnew opgroup block. It also keeps
// a sticky OR of the status flags of every result it hands out.
// Optional feature: define FPNEW_RESULT_BUF_BYPASS_EN so that an incoming
// result falls through to the output in the same cycle when the buffer is empty.
module fpnew_result_buffer
    import fpnew_pkg::*;
#(
    parameter int unsigned Width   = 32,
    parameter int unsigned Depth   = 4,
    parameter type         TagType = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [Width-1:0]           in_result_i,
    input  status_t                    in_status_i,
    input  logic                       in_ext_bit_i,
    input  TagType                     in_tag_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       flush_i,
    output logic [Width-1:0]           out_result_o,
    output status_t                    out_status_o,
    output logic                       out_ext_bit_o,
    output TagType                     out_tag_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    input  logic                       clear_status_i,
    output status_t                    status_acc_o,
    output logic [$clog2(Depth):0]     usage_o,
    output logic                       busy_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    typedef struct packed {
        logic [Width-1:0] result;
        status_t          status;
        logic             ext_bit;
        TagType           tag;
    } entry_t;

    entry_t           mem_q [Depth];
    entry_t           in_entry;
    entry_t           head;
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddrW:0]   usage_q, usage_d;
    status_t          acc_q, acc_d;
    status_t          pop_status;
    logic             empty, full;
    logic             push, pop, store, unload;

    assign in_entry = '{result: in_result_i, status: in_status_i,
                        ext_bit: in_ext_bit_i, tag: in_tag_i};

    assign empty      = (usage_q == '0);
    assign full       = (usage_q == (AddrW + 1)'(Depth));
    assign in_ready_o = !full;

`ifdef FPNEW_RESULT_BUF_BYPASS_EN
    assign out_valid_o = !empty || in_valid_i;
    assign head        = empty ? in_entry : mem_q[rd_ptr_q];
`else
    assign out_valid_o = !empty;
    assign head        = mem_q[rd_ptr_q];
`endif

    // A pop while empty can only be a fall-through: it consumes the incoming
    // entry, so nothing is stored and the read side does not move.
    assign push   = in_valid_i && in_ready_o && !flush_i;
    assign pop    = out_valid_o && out_ready_i && !flush_i;
    assign store  = push && !(empty && pop);
    assign unload = pop && !empty;

    assign out_result_o  = head.result;
    assign out_status_o  = head.status;
    assign out_ext_bit_o = head.ext_bit;
    assign out_tag_o     = head.tag;
    assign busy_o        = out_valid_o;
    assign usage_o       = usage_q;
    assign status_acc_o  = acc_q;

    // Next-state for pointers, fill level and sticky status.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        usage_d    = usage_q;
        pop_status = pop ? head.status : '0;
        acc_d      = clear_status_i ? pop_status : (acc_q | pop_status);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usage_d  = '0;
        end else begin
            if (store)  wr_ptr_d = wr_ptr_q + AddrW'(1);
            if (unload) rd_ptr_d = rd_ptr_q + AddrW'(1);
            case ({store, unload})
                2'b10:   usage_d = usage_q + (AddrW + 1)'(1);
                2'b01:   usage_d = usage_q - (AddrW + 1)'(1);
                default: usage_d = usage_q;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
            acc_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usage_q  <= usage_d;
            acc_q    <= acc_d;
        end
    end

    // Entry storage; contents need no reset since usage gates visibility.
    always_ff @(posedge clk_i) begin
        if (store && !rst_i) mem_q[wr_ptr_q] <= in_entry;
    end

endmodule

// File: tb/tb_fpnew_result_buffer.sv
// Directed self-checking bench for fpnew_result_buffer (Depth=4, Width=32).
// Also covers the fall-through path when FPNEW_RESULT_BUF_BYPASS_EN is defined.
module tb_fpnew_result_buffer;
    import fpnew_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      in_result;
    status_t          in_status;
    logic             in_ext;
    logic [3:0]       in_tag;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [31:0]      out_result;
    status_t          out_status;
    logic             out_ext;
    logic [3:0]       out_tag;
    logic             out_valid;
    logic             out_ready;
    logic             clear_status;
    status_t          status_acc;
    logic [2:0]       usage;
    logic             busy;

    int errors = 0;
    int checks = 0;

    localparam status_t ST_NONE = 5'b00000;
    localparam status_t ST_NX   = 5'b00001;
    localparam status_t ST_OF   = 5'b00100;
    localparam status_t ST_DZ   = 5'b01000;

    fpnew_result_buffer #(
        .Width   (32),
        .Depth   (4),
        .TagType (logic [3:0])
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .in_result_i    (in_result),
        .in_status_i    (in_status),
        .in_ext_bit_i   (in_ext),
        .in_tag_i       (in_tag),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .flush_i        (flush),
        .out_result_o   (out_result),
        .out_status_o   (out_status),
        .out_ext_bit_o  (out_ext),
        .out_tag_o      (out_tag),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .clear_status_i (clear_status),
        .status_acc_o   (status_acc),
        .usage_o        (usage),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] r, input status_t s, input logic [3:0] t);
        in_result = r;
        in_status = s;
        in_tag    = t;
        in_ext    = t[0];
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        clear_status = 1'b0;
        set_in(32'h0, ST_NONE, 4'h0);
        tick(); tick();

        check("rst_usage",  64'(usage), 64'd0);
        check("rst_valid",  64'(out_valid), 64'd0);
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_ready",  64'(in_ready), 64'd1);
        check("rst_acc",    64'(status_acc), 64'd0);
        rst = 1'b0;
        tick();

`ifdef FPNEW_RESULT_BUF_BYPASS_EN
        // Fall-through on an empty buffer.
        set_in(32'h0000ABCD, ST_OF, 4'h3);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("byp_valid",  64'(out_valid), 64'd1);
        check("byp_result", 64'(out_result), 64'h0000ABCD);
        check("byp_tag",    64'(out_tag), 64'h3);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("byp_usage",  64'(usage), 64'd0);
        check("byp_acc",    64'(status_acc), 64'(ST_OF));
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        check("byp_clr",    64'(status_acc), 64'd0);
`else
        // Single push: visible one cycle later, never in the push cycle.
        set_in(32'h3F800000, ST_NONE, 4'h1);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("lat_nosame", 64'(out_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        check("lat_valid",  64'(out_valid), 64'd1);
        check("lat_result", 64'(out_result), 64'h3F800000);
        check("lat_tag",    64'(out_tag), 64'h1);
        check("lat_usage",  64'(usage), 64'd1);
        tick();
        check("lat_drain",  64'(out_valid), 64'd0);
        out_ready = 1'b0;
`endif

        // Fill to Depth with the consumer stalled; the fifth stays upstream.
        for (int i = 1; i <= 4; i++) begin
            set_in(32'(i), ST_NONE, 4'(i));
            in_valid = 1'b1;
            tick();
        end
        check("full_usage", 64'(usage), 64'd4);
        check("full_ready", 64'(in_ready), 64'd0);
        set_in(32'd5, ST_NONE, 4'd5);
        tick();
        check("full_hold",  64'(usage), 64'd4);
        check("full_stable",64'(out_result), 64'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("order_res%0d", i), 64'(out_result), 64'(i));
            check($sformatf("order_tag%0d", i), 64'(out_tag), 64'(i));
            check($sformatf("order_ext%0d", i), 64'(out_ext), 64'(i % 2));
            tick();
        end
        out_ready = 1'b0;
        check("order_empty", 64'(usage), 64'd0);

        // Full buffer with simultaneous push and pop: the pop wins alone.
        for (int i = 0; i < 4; i++) begin
            set_in(32'(10 + i), ST_NONE, 4'(i));
            in_valid = 1'b1;
            tick();
        end
        set_in(32'd99, ST_NONE, 4'hF);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("fpp_usage", 64'(usage), 64'd3);
        check("fpp_ready", 64'(in_ready), 64'd1);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("fpp_res%0d", i), 64'(out_result), 64'(10 + i));
            tick();
        end
        out_ready = 1'b0;
        check("fpp_empty", 64'(usage), 64'd0);
        check("fpp_acc0",  64'(status_acc), 64'd0);

        // Sticky status and clear-with-pop.
        set_in(32'hA1, ST_NX, 4'h1); in_valid = 1'b1; tick();
        set_in(32'hA2, ST_OF, 4'h2); tick();
        set_in(32'hA3, ST_DZ, 4'h3); tick();
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        check("acc_or",    64'(status_acc), 64'(ST_NX | ST_OF));
        clear_status = 1'b1; out_ready = 1'b1;
        tick();
        clear_status = 1'b0; out_ready = 1'b0;
        check("acc_clrpop", 64'(status_acc), 64'(ST_DZ));
        check("acc_usage",  64'(usage), 64'd0);

        // Flush with three held entries plus a same-cycle push and pop.
        for (int i = 0; i < 3; i++) begin
            set_in(32'(32'hB0 + i), ST_NX, 4'(i));
            in_valid = 1'b1;
            tick();
        end
        check("pre_flush", 64'(usage), 64'd3);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("flush_usage", 64'(usage), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_busy",  64'(busy), 64'd0);
        check("flush_acc",   64'(status_acc), 64'(ST_DZ));
        set_in(32'h77, ST_NONE, 4'h7); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("postflush_res",   64'(out_result), 64'h77);
        check("postflush_usage", 64'(usage), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset mid-fill drops entries and the sticky status.
        set_in(32'hC0, ST_NONE, 4'h1); in_valid = 1'b1; tick();
        set_in(32'hC1, ST_NONE, 4'h2); tick();
        check("prerst_usage", 64'(usage), 64'd2);
        in_valid = 1'b0; rst = 1'b1;
        tick();
        check("mrst_usage", 64'(usage), 64'd0);
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_ready", 64'(in_ready), 64'd1);
        check("mrst_acc",   64'(status_acc), 64'd0);
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
